// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//   Handshake and data bundle for the bit-serial adder.
//
//   start_in   requester -> adder   start an operation (honoured in IDLE only)
//   a_in       requester -> adder   operand A, WIDTH bits
//   b_in       requester -> adder   operand B, WIDTH bits
//   busy_out   adder -> requester   operation in progress (RUN or DONE)
//   done_out   adder -> requester   one-cycle pulse, result valid
//   sum_out    adder -> requester   result bits [WIDTH-1:0]
//   carry_out  adder -> requester   result bit WIDTH
//
//   master: the requester side; slave: the adder side.
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  modport master (
    output start_in,
    output a_in,
    output b_in,
    input  busy_out,
    input  done_out,
    input  sum_out,
    input  carry_out
  );

  modport slave (
    input  start_in,
    input  a_in,
    input  b_in,
    output busy_out,
    output done_out,
    output sum_out,
    output carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   Single-bit half adder.
//   a_in, b_in   addend bits
//   sum_out      a_in ^ b_in
//   carry_out    a_in & b_in
//
// serial_adder
//   Bit-serial unsigned adder: {carry_out, sum_out} = a + b, one bit per
//   clock, LSB first. Two cascaded half adders plus an OR form the full
//   adder for the current bit; a registered carry links successive bits.
//
//   clk_in   clock, rising edge
//   rst_in   synchronous active-high reset
//   bus      serial_adder_if.slave (start/operands in, busy/done/result out)
//
//   Timeline for a start accepted at edge E0: RUN in cycles 1..WIDTH,
//   DONE (done_out pulse) in cycle WIDTH+1, back in IDLE from WIDTH+2.
// ---------------------------------------------------------------------------
module half_adder (
  input  logic a_in,
  input  logic b_in,
  output logic sum_out,
  output logic carry_out
);
  assign sum_out   = a_in ^ b_in;
  assign carry_out = a_in & b_in;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  serial_adder_if.slave bus
);
  // Counter needs at least one bit so WIDTH=1 still elaborates cleanly.
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy;
  logic             done;

  logic h1_sum;
  logic h1_carry;
  logic h2_sum;
  logic h2_carry;

  // Full adder for the current bit: operands always sit at bit 0 because
  // the operand registers shift right once per RUN cycle.
  half_adder u_h1 (
    .a_in      (a_reg[0]),
    .b_in      (b_reg[0]),
    .sum_out   (h1_sum),
    .carry_out (h1_carry)
  );

  half_adder u_h2 (
    .a_in      (h1_sum),
    .b_in      (carry_reg),
    .sum_out   (h2_sum),
    .carry_out (h2_carry)
  );

  // Result enters at the MSB and shifts right, so after WIDTH shifts the
  // first (LSB) result bit lands at position 0.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res
    if (gi == WIDTH - 1) begin : g_msb
      assign res_next[gi] = h2_sum;
    end else begin : g_shift
      assign res_next[gi] = res_reg[gi+1];
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start_in) state_next = RUN;
      RUN:     if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: purely from the state register, so busy/done have no
  // combinational path from any input.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operands, result, carry and bit counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_in) begin
            a_reg     <= bus.a_in;
            b_reg     <= bus.b_in;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          res_reg   <= res_next;
          carry_reg <= h1_carry | h2_carry;
          cnt_reg   <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_out  = busy;
  assign bus.done_out  = done;
  assign bus.sum_out   = res_reg;
  assign bus.carry_out = carry_reg;
endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder: a WIDTH=8 instance exercised with a
//   vector table, hand-written corner sequences and random operands, and a
//   WIDTH=1 instance. Expected results come from plain a+b arithmetic and
//   expected timing from WIDTH.
// ---------------------------------------------------------------------------
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus8.slave)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus1.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One 8-bit operation started from IDLE. Checks busy/done every cycle
  // through the return to IDLE, the result in DONE and its hold in IDLE.
  // mid_start pulses start_in with zero operands while RUN is in progress.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit mid_start,
                      output logic [7:0] sum, output logic carry);
    int         dones;
    logic [8:0] ref_v;
    dones = 0;
    ref_v = {1'b0, a} + {1'b0, b};
    sum   = '0;
    carry = 1'b0;
    @(negedge clk);
    bus8.start_in = 1'b1;
    bus8.a_in     = a;
    bus8.b_in     = b;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus8.start_in = 1'b0;
        bus8.a_in     = 8'($urandom);
        bus8.b_in     = 8'($urandom);
      end
      if (mid_start && k == 4) begin
        bus8.start_in = 1'b1;
        bus8.a_in     = 8'h00;
        bus8.b_in     = 8'h00;
      end
      if (mid_start && k == 5) bus8.start_in = 1'b0;
      check("busy8", 32'(bus8.busy_out), 32'(k <= 9));
      check("done8", 32'(bus8.done_out), 32'(k == 9));
      if (bus8.done_out) dones++;
      if (k >= 9) begin
        check("sum8", 32'(bus8.sum_out), 32'(ref_v[7:0]));
        check("carry8", 32'(bus8.carry_out), 32'(ref_v[8]));
      end
      if (k == 9) begin
        sum   = bus8.sum_out;
        carry = bus8.carry_out;
      end
    end
    check("done8_count", 32'(dones), 32'd1);
    $display("op8 a=%02h b=%02h -> sum=%02h carry=%0d (mid_start=%0d)", a, b, sum, carry, mid_start);
  endtask

  task automatic run1(input logic a, input logic b);
    logic [1:0] ref_v;
    ref_v = {1'b0, a} + {1'b0, b};
    @(negedge clk);
    bus1.start_in = 1'b1;
    bus1.a_in     = a;
    bus1.b_in     = b;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus1.start_in = 1'b0;
        bus1.a_in     = ~a;
        bus1.b_in     = ~b;
      end
      check("busy1", 32'(bus1.busy_out), 32'(k <= 2));
      check("done1", 32'(bus1.done_out), 32'(k == 2));
      if (k >= 2) begin
        check("sum1", 32'(bus1.sum_out), 32'(ref_v[0]));
        check("carry1", 32'(bus1.carry_out), 32'(ref_v[1]));
      end
    end
    $display("op1 a=%0d b=%0d -> sum=%0d carry=%0d", a, b, bus1.sum_out, bus1.carry_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    logic       c;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1};
    vecs[2] = '{a: 8'h35, b: 8'h4A, sum: 8'h7F, carry: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h80, sum: 8'h00, carry: 1'b1};
    vecs[4] = '{a: 8'h10, b: 8'h20, sum: 8'h30, carry: 1'b0};
    vecs[5] = '{a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0};

    bus8.start_in = 1'b0;
    bus8.a_in     = '0;
    bus8.b_in     = '0;
    bus1.start_in = 1'b0;
    bus1.a_in     = '0;
    bus1.b_in     = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(bus8.busy_out), 32'd0);
    check("rst_done8", 32'(bus8.done_out), 32'd0);
    check("rst_sum8", 32'(bus8.sum_out), 32'd0);
    check("rst_carry8", 32'(bus8.carry_out), 32'd0);
    check("rst_busy1", 32'(bus1.busy_out), 32'd0);
    rst = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, 1'b0, s, c);
      check("vec_sum", 32'(s), 32'(vecs[i].sum));
      check("vec_carry", 32'(c), 32'(vecs[i].carry));
      if (i == 1) begin
        // FF+FF result must stay put while idle
        repeat (5) @(negedge clk);
        check("hold_sum", 32'(bus8.sum_out), 32'h0FE);
        check("hold_carry", 32'(bus8.carry_out), 32'd1);
      end
    end

    // Start re-pulsed mid-RUN with zero operands: ignored
    run8(8'h35, 8'h4A, 1'b1, s, c);
    check("midstart_sum", 32'(s), 32'h07F);
    repeat (3) begin
      @(negedge clk);
      check("midstart_no_extra_done", 32'(bus8.done_out), 32'd0);
    end

    // start_in held high: back-to-back ops every 10 cycles
    @(negedge clk);
    bus8.start_in = 1'b1;
    bus8.a_in     = 8'h10;
    bus8.b_in     = 8'h20;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check("held_busy", 32'(bus8.busy_out), 32'((k % 10) != 0));
      check("held_done", 32'(bus8.done_out), 32'((k % 10) == 9));
      if ((k % 10) == 9) begin
        check("held_sum", 32'(bus8.sum_out), 32'h030);
        check("held_carry", 32'(bus8.carry_out), 32'd0);
        $display("held op k=%0d sum=%02h carry=%0d", k, bus8.sum_out, bus8.carry_out);
      end
      if (k == 30) bus8.start_in = 1'b0;
    end

    // Reset during RUN cycle 4
    @(negedge clk);
    bus8.start_in = 1'b1;
    bus8.a_in     = 8'h35;
    bus8.b_in     = 8'h4A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus8.start_in = 1'b0;
    end
    check("prerst_busy", 32'(bus8.busy_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus8.busy_out), 32'd0);
    check("midrst_done", 32'(bus8.done_out), 32'd0);
    check("midrst_sum", 32'(bus8.sum_out), 32'd0);
    check("midrst_carry", 32'(bus8.carry_out), 32'd0);
    repeat (10) begin
      @(negedge clk);
      check("postrst_quiet", 32'({bus8.busy_out, bus8.done_out}), 32'd0);
    end
    $display("reset during RUN applied");
    run8(8'h80, 8'h80, 1'b0, s, c);
    check("postrst_sum", 32'(s), 32'h000);
    check("postrst_carry", 32'(c), 32'd1);

    // Start coincident with reset is dropped
    @(negedge clk);
    rst           = 1'b1;
    bus8.start_in = 1'b1;
    bus8.a_in     = 8'h55;
    bus8.b_in     = 8'h55;
    @(negedge clk);
    rst           = 1'b0;
    bus8.start_in = 1'b0;
    check("rst_start_busy", 32'(bus8.busy_out), 32'd0);
    @(negedge clk);
    check("rst_start_busy2", 32'(bus8.busy_out), 32'd0);
    $display("start with reset dropped");

    // Random operands against a+b
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, 1'b0, s, c);
    end

    // WIDTH=1 instance
    run1(1'b1, 1'b1);
    check("w1_sum", 32'(bus1.sum_out), 32'd0);
    check("w1_carry", 32'(bus1.carry_out), 32'd1);
    run1(1'b0, 1'b0);
    run1(1'b1, 1'b0);
    run1(1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      run1(1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder that sums two WIDTH-bit operands one bit per clock, LSB first. Each bit slice uses two cascaded `half_adder` instances and an OR gate to form the full-adder function; a registered carry links successive bits. The block is the sequential consumer of `half_adder`'s `sum_out`/`carry_out`, trading latency for area in narrow datapaths. A start/busy/done handshake frames each operation.

## Interface
- WIDTH, 8, operand width in bits; legal range 1..32.

- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request; accepted only when the block is in IDLE.
- a_in  input  WIDTH  operand A; sampled only at the accepting edge.
- b_in  input  WIDTH  operand B; sampled only at the accepting edge.
- busy_out  output  1  high in RUN and DONE.
- done_out  output  1  one-cycle pulse; result valid.
- sum_out  output  WIDTH  result bits [WIDTH-1:0].
- carry_out  output  1  final carry (bit WIDTH of the sum).

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: if start_in=1 at an edge, capture a_in/b_in into shift registers, clear carry register, clear bit counter, clear result register, go to RUN. Otherwise stay in IDLE.
- RUN: each edge processes bit i = counter value.
  - h1 = half_adder(a[i], b[i]); h2 = half_adder(h1.sum, carry_reg).
  - Result bit = h2.sum, shifted into the result register from the MSB side (shift right), so bit 0 ends at position 0 after WIDTH shifts.
  - carry_reg <= h1.carry | h2.carry.
  - Operand registers shift right by one. Counter increments.
  - After the WIDTH-th RUN edge (counter reaches WIDTH-1 when sampled), go to DONE.
- DONE: done_out=1 for exactly this cycle. Next edge goes to IDLE unconditionally.
- sum_out/carry_out are driven from the result and carry registers. They are final from the DONE cycle and hold until the next accepted start clears them.
- start_in is ignored in RUN and DONE, with no queuing. Operand changes after acceptance have no effect.
- Arithmetic: {carry_out, sum_out} = a + b, unsigned, exact. No overflow is possible in WIDTH+1 bits.
- WIDTH=1: one RUN cycle, then DONE.

## Timing
- Reset (rst_in=1 at an edge) overrides everything, including mid-operation:
  - state = IDLE.
  - busy_out=0, done_out=0, sum_out=0, carry_out=0.
  - Counter, operand, and carry registers = 0.
  - A start_in coincident with reset is dropped.
- Start accepted at edge E0 (cycle 0 -> cycle 1):
  - busy_out=1 from cycle 1.
  - RUN occupies cycles 1..WIDTH.
  - DONE (done_out=1) in cycle WIDTH+1.
  - IDLE (busy_out=0) from cycle WIDTH+2.
- Latency from accepting edge to done_out: WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles. With start_in held high, a new operation is accepted at the first IDLE edge.
- busy_out and done_out are registered, with no combinational path from inputs.
- During RUN, sum_out shows partial, shifting values and is not valid.

## Test plan
- WIDTH=8, a=0x35, b=0x4A, start one cycle:
  - done_out high exactly 9 cycles after the accepting edge.
  - sum_out=0x7F, carry_out=0.
  - busy_out high for 9 cycles.
- a=0xFF, b=0x01 -> sum_out=0x00, carry_out=1. Then a=0xFF, b=0xFF -> sum_out=0xFE, carry_out=1. Result held stable in IDLE until the next start.
- Start pulsed again mid-RUN, with a_in/b_in changed to 0x00 after acceptance:
  - Original result 0x35+0x4A=0x7F unaffected.
  - Exactly one done_out pulse.
- start_in held high continuously with a=0x10, b=0x20:
  - done_out pulses every 10 cycles.
  - One idle cycle with busy_out=0 between operations.
  - Each result = 0x30, carry 0.
- rst_in asserted during RUN cycle 4:
  - Next cycle all outputs 0, state IDLE, no done_out.
  - A subsequent start of 0x80+0x80 yields sum_out=0x00, carry_out=1.
- WIDTH=1 build, a=1, b=1 -> done_out 2 cycles after acceptance, sum_out=0, carry_out=1.
